// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

  // Only 32-bit addresses and instructions are supported.
  localparam int XLEN = 32;

  // Default PC after reset; the top exposes it as a parameter.
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // addi x0, x0, 0 -- what the decoder sees before the first fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch-stage state encoding.
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_e;

  // A fetch target is misaligned when it is not word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jalr > (jal | taken branch) > sequential, plus misalignment flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the target is consumed.
// Build option FETCH_MISALIGN_TRAP_EN: when undefined, target bits [1:0] are cleared here.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_target;

  // Priority mux; jalr drops bit 0 as the ISA requires, the add wraps mod 2^32.
  always_comb begin
    raw_target = pc + 32'd4;
    if (jalr) begin
      raw_target = {alu_result[XLEN-1:1], 1'b0};
    end else if (jump || branch) begin
      raw_target = pc + imm_ext;
    end
    misaligned = is_misaligned(raw_target);
`ifdef FETCH_MISALIGN_TRAP_EN
    target = raw_target;
`else
    // Without the trap, a misaligned target is rounded down to the word.
    target = {raw_target[XLEN-1:2], 2'b00};
`endif
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, imem req/ack fetch FSM (RST/FETCH/EXEC[/TRAP]) and retired-instruction counter.
// Latency: 2 cycles per instruction minimum (FETCH with same-cycle ack, then EXEC); +1 per ack-wait or stall cycle.
// Backpressure: imem_req held until imem_ack; stall holds EXEC. Build option FETCH_MISALIGN_TRAP_EN adds the TRAP state.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VEC = fetch_pkg::DEFAULT_RESET_VEC,
  parameter int          XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  // to decoder / datapath
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  // resolved controls from decoder
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  // status
  output logic [XLEN-1:0] instret,
  output logic            trap
);

  import fetch_pkg::*;

  // Flat state constants so the encoding stays visible in waveforms and legacy tools.
  localparam logic [1:0] S_RST   = ST_RST;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_EXEC  = ST_EXEC;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP  = ST_TRAP;
`endif

  logic [1:0]      state_q,       state_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic [XLEN-1:0] instr_q,       instr_d;
  logic [XLEN-1:0] instret_q,     instret_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q,    imem_req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            trap_q,        trap_d;
`endif

  logic [XLEN-1:0] tgt_pc;
  logic            tgt_misaligned;

  next_pc_sel u_next_pc_sel (
    .pc         (pc_q),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .target     (tgt_pc),
    .misaligned (tgt_misaligned)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  // The misaligned flag has no consumer when the trap is compiled out.
  logic unused_tgt_misaligned;
  assign unused_tgt_misaligned = tgt_misaligned;
`endif

  // FSM next-state, PC update, instruction capture and retire counting.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      S_RST: begin
        // One settling cycle after reset release; any ack here is ignored.
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (tgt_misaligned) begin
            // Architectural state is frozen at the faulting instruction.
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end else begin
            pc_d      = tgt_pc;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
`else
          pc_d      = tgt_pc;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: begin
        // Sticky until reset.
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_RST;
      end
    endcase
    // Handshake/valid outputs are registered decodes of the next state.
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_EXEC);
  end

  // State registers; reset drops any in-flight fetch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RST;
      pc_q          <= RESET_VEC;
      instr_q       <= NOP_INSTR;
      instret_q     <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q        <= trap_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instret     = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with RESET_VEC = 0x100.
// Table of next-PC vectors chained from the reset PC, plus hand sequences for
// ack delay/stall timing, reset during fetch, instret wrap and misaligned jal.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [31:0] alu_result = '0;
  logic        stall = 1'b0;
  logic [31:0] instret;
  logic        trap;

  fetch_pc_unit #(.RESET_VEC(32'h0000_0100), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .stall      (stall),
    .instret    (instret),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] cur_pc;
  logic [31:0] exp_instret;

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic        jp;
    logic        jr;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pc"}, pc, 32'h0000_0100);
    check({tag, " instr"}, instr, 32'h0000_0013);
    check({tag, " instret"}, instret, 32'd0);
    check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, " trap"}, {31'd0, trap}, 32'd0);
  endtask

  // Starts and ends at a negedge with the DUT in FETCH at cur_pc.
  task automatic run_instr(input string tag, input logic [31:0] rdata,
                           input int ack_dly, input int stall_n,
                           input logic br, input logic jp, input logic jr,
                           input logic [31:0] imm, input logic [31:0] alu,
                           input logic [31:0] nxt, output int cycles);
    cycles = 0;
    check({tag, " req"}, {31'd0, imem_req}, 32'd1);
    check({tag, " addr"}, imem_addr, cur_pc);
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); cycles++;
      @(negedge clk);
      check({tag, " req held"}, {31'd0, imem_req}, 32'd1);
      check({tag, " no valid while waiting"}, {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(posedge clk); cycles++;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    check({tag, " instr"}, instr, rdata);
    check({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, " pc"}, pc, cur_pc);
    check({tag, " pc_plus4"}, pc_plus4, cur_pc + 32'd4);
    check({tag, " req low in exec"}, {31'd0, imem_req}, 32'd0);
    branch = br; jump = jp; jalr = jr; imm_ext = imm; alu_result = alu;
    stall = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      @(posedge clk); cycles++;
      @(negedge clk);
      check({tag, " stall pc"}, pc, cur_pc);
      check({tag, " stall instr"}, instr, rdata);
      check({tag, " stall valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, " stall instret"}, instret, exp_instret);
    end
    stall = 1'b0;
    @(posedge clk); cycles++;
    @(negedge clk);
    branch = 1'b0; jump = 1'b0; jalr = 1'b0; imm_ext = '0; alu_result = '0;
    exp_instret = exp_instret + 32'd1;
    cur_pc = nxt;
    check({tag, " next pc"}, pc, nxt);
    check({tag, " next addr"}, imem_addr, nxt);
    check({tag, " next req"}, {31'd0, imem_req}, 32'd1);
    check({tag, " instret"}, instret, exp_instret);
  endtask

  initial begin
    int cyc;
    //            rdata         br    jp    jr    imm            alu            expected next pc
    vecs[0] = '{32'h0050_0093, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0104};
    vecs[1] = '{32'h0010_0113, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0108};
    vecs[2] = '{32'h0F80_006F, 1'b0, 1'b1, 1'b0, 32'h0000_00F8, 32'h0,         32'h0000_0200};
    vecs[3] = '{32'hFE20_88E3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0000_01F0};
    vecs[4] = '{32'h0100_006F, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0200};
    vecs[5] = '{32'h0000_8067, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0301, 32'h0000_0300};
    vecs[6] = '{32'h0000_80E7, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5679, 32'h1234_5678};
    vecs[7] = '{32'h0000_0463, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5680};
    vecs[8] = '{32'h5555_506F, 1'b0, 1'b1, 1'b0, 32'hEDCB_A97C, 32'h0,         32'hFFFF_FFFC};
    vecs[9] = '{32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000};

    // Reset state, with an ack wiggling that must be ignored.
    #1 rst_n = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("first req 1 cycle after reset", {31'd0, imem_req}, 32'd1);
    check("first addr", imem_addr, 32'h0000_0100);
    cur_pc = 32'h0000_0100;
    exp_instret = 32'd0;

    // Next-PC table, each instruction with same-cycle ack and no stall.
    for (int k = 0; k < 10; k++) begin
      run_instr($sformatf("vec%0d", k), vecs[k].rdata, 0, 0, vecs[k].br, vecs[k].jp,
                vecs[k].jr, vecs[k].imm, vecs[k].alu, vecs[k].exp_next, cyc);
      check($sformatf("vec%0d cycles", k), cyc, 32'd2);
    end

    // 3-cycle ack delay plus 2 stall cycles: 4 fetch + 3 exec = 7 cycles.
    run_instr("delay_stall", 32'h00A0_0513, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
              32'h0000_0004, cyc);
    check("delay_stall cycles", cyc, 32'd7);

    // Reset pulsed during FETCH while ack arrives: the ack must be dropped.
    check("pre-reset req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    check("async reset pc", pc, 32'h0000_0100);
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid-fetch reset");
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset addr", imem_addr, 32'h0000_0100);
    check("post-reset instr", instr, 32'h0000_0013);
    cur_pc = 32'h0000_0100;
    exp_instret = 32'd0;

    // instret wrap: preload all-ones while fetching, one retirement wraps to 0.
    run_instr("pre-wrap", 32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
              32'h0000_0104, cyc);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.instret_q;
    @(negedge clk);
    exp_instret = 32'hFFFF_FFFF;
    run_instr("wrap", 32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
              32'h0000_0108, cyc);
    check("instret wrapped", instret, 32'd0);

    // jal to pc+6.
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_ack = 1'b1;
    imem_rdata = 32'h0060_006F;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    jump = 1'b1;
    imm_ext = 32'd6;
    @(posedge clk);
    @(negedge clk);
    jump = 1'b0;
    imm_ext = '0;
    check("trap set", {31'd0, trap}, 32'd1);
    check("trap pc held", pc, 32'h0000_0108);
    check("trap instret held", instret, 32'd0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      check("trap no req", {31'd0, imem_req}, 32'd0);
      check("trap no valid", {31'd0, instr_valid}, 32'd0);
      check("trap sticky", {31'd0, trap}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    imem_ack = 1'b0;
`else
    run_instr("misalign jal", 32'h0060_006F, 0, 0, 1'b0, 1'b1, 1'b0, 32'd6, 32'h0,
              32'h0000_010C, cyc);
    check("no trap", {31'd0, trap}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
